// File: rtl/crc_frame_pkg.sv
// rtl/crc_frame_pkg.sv - shared constants and types for the CRC-32 frame checker
package crc_frame_pkg;

    localparam logic [31:0] CRC_POLY = 32'h04C1_1DB7;
    localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        SYNC = 2'd0,
        IDLE = 2'd1,
        RUN  = 2'd2
    } fsm_state_e;

    // Bit positions inside the err vector {align, too_long, runt, bad_crc}
    localparam int ERR_BAD_CRC  = 0;
    localparam int ERR_RUNT     = 1;
    localparam int ERR_TOO_LONG = 2;
    localparam int ERR_ALIGN    = 3;

endpackage

// File: rtl/crc32_serial_step.sv
// rtl/crc32_serial_step.sv - combinational CRC-32 advance over DATA_W bits, MSB first
module crc32_serial_step
    import crc_frame_pkg::*;
#(
    parameter int DATA_W = 2
) (
    input  logic [31:0]       crc_in,
    input  logic [DATA_W-1:0] data,
    output logic [31:0]       crc_out
);

    // One unrolled shift-register step per data bit; bit DATA_W-1 enters first
    for (genvar i = 0; i < DATA_W; i++) begin : g_step
        logic [31:0] prev;
        logic        fb;
        logic [31:0] nxt;

        if (i == 0) begin : g_first
            assign prev = crc_in;
        end else begin : g_chain
            assign prev = g_step[i-1].nxt;
        end

        assign fb  = prev[31] ^ data[DATA_W-1-i];
        assign nxt = {prev[30:0], 1'b0} ^ ({32{fb}} & CRC_POLY);
    end

    assign crc_out = g_step[DATA_W-1].nxt;

endmodule

// File: rtl/crc_frame_checker.sv
// rtl/crc_frame_checker.sv - per-frame CRC-32/length checker with verdict pulse and counters
module crc_frame_checker
    import crc_frame_pkg::*;
#(
    parameter int          DATA_W    = 2,
    parameter logic [31:0] RESIDUE   = 32'h38FB_2284,
    parameter int          MIN_BYTES = 64,
    parameter int          MAX_BYTES = 1522,
    parameter int          CNT_W     = 16,
    parameter int          LEN_W     = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              axiiv,
    input  logic [DATA_W-1:0] axiid,
    input  logic              clr_cnt,
    output logic              done,
    output logic              kill,
    output logic [3:0]        err,
    output logic [LEN_W-1:0]  frame_len,
    output logic [CNT_W-1:0]  good_cnt,
    output logic [CNT_W-1:0]  bad_cnt
);

    localparam int BEATS_PER_BYTE = 8 / DATA_W;
    localparam int SHIFT          = $clog2(BEATS_PER_BYTE);
    localparam int BEAT_W         = LEN_W + SHIFT;

    localparam logic [BEAT_W-1:0] BEAT_MAX   = '1;
    localparam logic [BEAT_W-1:0] ALIGN_MASK = BEAT_W'(BEATS_PER_BYTE - 1);
    localparam logic [LEN_W-1:0]  MIN_LEN    = LEN_W'(MIN_BYTES);
    localparam logic [LEN_W-1:0]  MAX_LEN    = LEN_W'(MAX_BYTES);
    localparam logic [CNT_W-1:0]  CNT_MAX    = '1;

    fsm_state_e        state;
    logic [31:0]       crc_reg;
    logic [31:0]       crc_next;
    logic [BEAT_W-1:0] beat_cnt;
    logic [BEAT_W-1:0] beat_inc;
    logic [LEN_W-1:0]  byte_cnt;
    logic [3:0]        err_next;
    logic              frame_end;

    crc32_serial_step #(
        .DATA_W (DATA_W)
    ) u_step (
        .crc_in  (crc_reg),
        .data    (axiid),
        .crc_out (crc_next)
    );

    assign beat_inc  = (beat_cnt == BEAT_MAX) ? beat_cnt : beat_cnt + BEAT_W'(1);
    // A saturated beat count shifts down to an all-ones byte count
    assign byte_cnt  = LEN_W'(beat_cnt >> SHIFT);
    assign frame_end = (state == RUN) && !axiiv;

    always_comb begin
        err_next               = '0;
        err_next[ERR_BAD_CRC]  = (~crc_reg != RESIDUE);
        err_next[ERR_RUNT]     = (byte_cnt < MIN_LEN);
        err_next[ERR_TOO_LONG] = (byte_cnt > MAX_LEN);
        err_next[ERR_ALIGN]    = ((beat_cnt & ALIGN_MASK) != '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= SYNC;
            crc_reg   <= CRC_INIT;
            beat_cnt  <= '0;
            done      <= 1'b0;
            kill      <= 1'b0;
            err       <= '0;
            frame_len <= '0;
        end else begin
            done <= 1'b0;
            kill <= 1'b0;
            case (state)
                SYNC: begin
                    if (!axiiv) begin
                        state <= IDLE;
                    end
                end
                IDLE: begin
                    if (axiiv) begin
                        crc_reg  <= crc_next;
                        beat_cnt <= BEAT_W'(1);
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (axiiv) begin
                        crc_reg  <= crc_next;
                        beat_cnt <= beat_inc;
                    end else begin
                        done      <= 1'b1;
                        kill      <= |err_next;
                        err       <= err_next;
                        frame_len <= byte_cnt;
                        crc_reg   <= CRC_INIT;
                        beat_cnt  <= '0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= SYNC;
                end
            endcase
        end
    end

    // Counters move on the verdict edge so they line up with the done pulse
    always_ff @(posedge clk) begin
        if (!rst_n || clr_cnt) begin
            good_cnt <= '0;
            bad_cnt  <= '0;
        end else if (frame_end) begin
            if (|err_next) begin
                if (bad_cnt != CNT_MAX) begin
                    bad_cnt <= bad_cnt + CNT_W'(1);
                end
            end else begin
                if (good_cnt != CNT_MAX) begin
                    good_cnt <= good_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: doc/crc_frame_checker.md
Name: crc_frame_checker

Overview:
- Parametrised successor to the single-width FCS checker.
- Consumes the framed data stream, one frame per contiguous run of axiiv=1, and runs an internal CRC-32.
- At end of frame, reports pass/fail with error cause, frame length and running good/bad frame counters.
- Sits after the PHY bit-pair/byte aligner and before the frame buffer commit logic, which uses kill to discard frames.

Parameters:
- DATA_W, 2, beat width in bits; legal values 2, 4, 8.
- RESIDUE, 32'h38FB_2284, expected complemented CRC register value after a frame including its FCS.
- MIN_BYTES, 64, shortest legal frame including FCS.
- MAX_BYTES, 1522, longest legal frame including FCS.
- CNT_W, 16, width of the good/bad frame counters.
- LEN_W, 11, width of frame_len in bytes.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- axiiv  in  1  beat valid; high for the whole frame, low between frames
- axiid  in  DATA_W  beat data; bit DATA_W-1 is processed first
- clr_cnt  in  1  synchronous clear of good_cnt/bad_cnt
- done  out  1  one-cycle pulse, frame verdict valid
- kill  out  1  high with done when frame is bad; 0 whenever done=0
- err  out  4  {align, too_long, runt, bad_crc}; valid with done, held until next done
- frame_len  out  LEN_W  frame byte count (saturating); valid with done, held
- good_cnt  out  CNT_W  frames passed, saturating
- bad_cnt  out  CNT_W  frames killed, saturating

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - done=kill=0, err=0, frame_len=0, counters=0.
  - CRC register is set to 32'hFFFF_FFFF.
  - FSM goes to SYNC.
- FSM states:
  - SYNC: ignore input; go to IDLE on the first cycle with axiiv=0. This drops any frame that was already running when reset released.
  - IDLE: CRC held at FFFF_FFFF and beat count at 0; on axiiv=1, process that beat and go to RUN.
  - RUN:
    - With axiiv=1: process the beat.
    - With axiiv=0: evaluate the verdict, re-initialise the CRC and beat count, and go to IDLE.
- CRC algorithm:
  - Polynomial 04C11DB7, MSB-first, no reflection, init FFFF_FFFF.
  - DATA_W serial steps per beat, bit DATA_W-1 first.
  - bad_crc = (~crc_reg != RESIDUE).
- Length:
  - Beat counter width is LEN_W + log2(8/DATA_W), saturating.
  - Bytes = beats / (8/DATA_W), saturating at 2^LEN_W-1.
  - align = beats not a multiple of 8/DATA_W.
  - runt = bytes < MIN_BYTES.
  - too_long = bytes > MAX_BYTES.
- Verdict timing:
  - Last valid beat in cycle N; axiiv=0 sampled in cycle N+1.
  - done, kill, err and frame_len are registered at the N+1 edge and visible in cycle N+2 for exactly one cycle.
  - Latency is 2 cycles from the last beat.
- kill = |err.
- Counters:
  - good_cnt increments on done&~kill; bad_cnt increments on done&kill.
  - Both saturate at all-ones.
  - If clr_cnt and an increment occur in the same cycle, clr_cnt wins and the counter becomes 0.
- Back-to-back frames:
  - A single idle cycle is sufficient.
  - A new frame may start in cycle N+2, concurrent with the done pulse; its first beat uses the fresh FFFF_FFFF init.
- Single-beat frames are legal input and report runt (plus align if DATA_W<8).
- Reset mid-frame: no done is issued for the aborted frame and counters are cleared.
- axiid is don't-care while axiiv=0.

Decomposition:
- Package crc_frame_pkg holds:
  - CRC_POLY = 32'h04C1_1DB7 and CRC_INIT = 32'hFFFF_FFFF;
  - an enum for FSM states {SYNC, IDLE, RUN};
  - localparam bit indices for err fields.
- One sub-module, crc32_serial_step: combinational next-CRC for DATA_W bits (generate loop). It is reusable by the TX FCS generator.

Test Plan:
- DATA_W=2, 60 bytes 0x00..0x3B + correct FCS (240+16 beats) -> in cycle N+2: done=1, kill=0, err=0000, frame_len=64, good_cnt=1.
- Same frame with bit 0 of last FCS byte flipped -> done=1, kill=1, err=0001, frame_len=64, bad_cnt=1.
- 28 bytes + correct FCS (32-byte frame) -> kill=1, err=0010, frame_len=32; then 1600-byte frame with valid FCS -> err=0100, frame_len=1600.
- 64-byte frame plus one extra dibit (257 beats) -> err[3]=1 (plus bad_crc), kill=1.
- rst_n low for 1 cycle mid-frame, axiiv still high -> no done for that frame, counters 0; next frame after a gap verifies normally with good_cnt=1.
- Two valid frames separated by one idle cycle; CNT_W=2 with 5 good frames; clr_cnt coincident with done -> two done pulses, both kill=0; good_cnt saturates at 3; clr_cnt yields good_cnt=0.
